// File: rtl/dma_utils_pkg.sv
// Shared DMA types: streamer request/response, AXI field types and the
// mode-to-burst mapping used by the AXI address-channel responders.
package dma_utils_pkg;

   localparam int DMA_ADDR_WIDTH = 32;
   localparam int DMA_DATA_WIDTH = 32;

   typedef logic [DMA_ADDR_WIDTH-1:0]   axi_addr_t;
   typedef logic [7:0]                  axi_alen_t;
   typedef logic [2:0]                  axi_size_t;
   typedef logic [DMA_DATA_WIDTH/8-1:0] axi_wr_strb_t;

   typedef enum logic {
      DMA_MODE_FIXED = 1'b0,
      DMA_MODE_INCR  = 1'b1
   } dma_mode_t;

   typedef enum logic [1:0] {
      AXI_BURST_FIXED = 2'b00,
      AXI_BURST_INCR  = 2'b01,
      AXI_BURST_WRAP  = 2'b10
   } axi_burst_t;

   typedef struct packed {
      logic         valid;
      axi_addr_t    addr;
      axi_alen_t    alen;
      axi_size_t    size;
      axi_wr_strb_t strb;
      dma_mode_t    mode;
   } s_dma_axi_req_t;

   typedef struct packed {
      logic ready;
   } s_dma_axi_resp_t;

   // Per-burst descriptor handed to the data mover.
   typedef struct packed {
      axi_alen_t    alen;
      axi_wr_strb_t strb;
   } s_dma_dp_desc_t;

   function automatic axi_burst_t dma_mode_to_burst(input dma_mode_t mode);
      return (mode == DMA_MODE_INCR) ? AXI_BURST_INCR : AXI_BURST_FIXED;
   endfunction

endpackage

// File: rtl/dma_fifo.sv
// Parameterised synchronous FIFO, first-word fall-through, DEPTH a power of 2.
// Push when full is accepted only alongside a pop; pop when empty is ignored.
module dma_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push_en;
   logic             pop_en;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_en  = pop & ~empty;
   assign push_en = push & (~full | pop_en);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // NOTE: registers use <= so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is not reset; pointers alone define validity, keeping it a plain RAM.
   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/dma_axi_addr_if.sv
// Streamer-to-AXI address channel responder (AR or AW): issues bursts, bounds
// outstanding transactions and queues {alen, strb} descriptors for the data mover.
module dma_axi_addr_if
   import dma_utils_pkg::*;
#(
   parameter int STREAM_TYPE     = 0,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  s_dma_axi_req_t            dma_axi_req_i,
   output s_dma_axi_resp_t           dma_axi_resp_o,
   output logic [DMA_ADDR_WIDTH-1:0] ax_addr_o,
   output logic [7:0]                ax_len_o,
   output logic [2:0]                ax_size_o,
   output logic [1:0]                ax_burst_o,
   output logic                      ax_valid_o,
   input  logic                      ax_ready_i,
   input  logic                      txn_done_i,
   input  logic                      txn_err_i,
   output logic                      dp_valid_o,
   output logic [7:0]                dp_alen_o,
   output axi_wr_strb_t              dp_strb_o,
   input  logic                      dp_ready_i,
   input  logic                      err_clr_i,
   output logic                      err_o,
   output logic                      idle_o
);

   localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

   if (STREAM_TYPE < 0 || STREAM_TYPE > 1 || MAX_OUTSTANDING < 2 || MAX_OUTSTANDING > 16 ||
       (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_param
      $error("dma_axi_addr_if: illegal STREAM_TYPE or MAX_OUTSTANDING");
   end

   logic           ready;
   logic           accept;
   logic           done_ok;
   logic           underflow;
   logic           err_set;
   logic [CW-1:0]  os_cnt;
   logic [CW-1:0]  os_cnt_nxt;
   axi_burst_t     ax_burst_q;
   s_dma_dp_desc_t push_desc;
   s_dma_dp_desc_t head_desc;
   logic           fifo_full;
   logic           fifo_empty;

   assign ready                = (~ax_valid_o | ax_ready_i) & (os_cnt < CW'(MAX_OUTSTANDING));
   assign dma_axi_resp_o.ready = ready;
   assign accept               = dma_axi_req_i.valid & ready;
   assign done_ok              = txn_done_i & (os_cnt != '0);
   assign underflow            = txn_done_i & (os_cnt == '0);
   assign err_set              = (txn_done_i & txn_err_i) | underflow;

   // Address register: payload held stable until the slave takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         ax_valid_o <= 1'b0;
         ax_addr_o  <= '0;
         ax_len_o   <= '0;
         ax_size_o  <= '0;
         ax_burst_q <= AXI_BURST_FIXED;
      end else if (accept) begin
         ax_valid_o <= 1'b1;
         ax_addr_o  <= dma_axi_req_i.addr;
         ax_len_o   <= dma_axi_req_i.alen;
         ax_size_o  <= dma_axi_req_i.size;
         ax_burst_q <= dma_mode_to_burst(dma_axi_req_i.mode);
      end else if (ax_ready_i) begin
         ax_valid_o <= 1'b0;
      end
   end

   assign ax_burst_o = ax_burst_q;

   // NOTE: the default assignment first keeps this block purely combinational (no latch).
   always_comb begin
      os_cnt_nxt = os_cnt;
      case ({accept, done_ok})
         2'b10:   os_cnt_nxt = os_cnt + CW'(1);
         2'b01:   os_cnt_nxt = os_cnt - CW'(1);
         default: os_cnt_nxt = os_cnt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         os_cnt <= '0;
         err_o  <= 1'b0;
      end else begin
         os_cnt <= os_cnt_nxt;
         if (err_set)        err_o <= 1'b1;
         else if (err_clr_i) err_o <= 1'b0;
      end
   end

   assign push_desc.alen = dma_axi_req_i.alen;
   assign push_desc.strb = dma_axi_req_i.strb;

   dma_fifo #(
      .WIDTH ($bits(s_dma_dp_desc_t)),
      .DEPTH (MAX_OUTSTANDING)
   ) u_desc_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (accept),
      .wr_data (push_desc),
      .pop     (dp_ready_i),
      .rd_data (head_desc),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign dp_valid_o = ~fifo_empty;
   assign dp_alen_o  = head_desc.alen;
   assign dp_strb_o  = head_desc.strb;
   assign idle_o     = ~ax_valid_o & (os_cnt == '0) & fifo_empty;

   // The outstanding limit must keep the descriptor queue from overflowing.
   a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
      !(accept && fifo_full && !dp_ready_i));

endmodule

// File: doc/dma_axi_addr_if.md
# dma_axi_addr_if

Responder side of the streamer request interface. It accepts `s_dma_axi_req_t` burst requests from one `dma_streamer` instance and issues them on an AXI address channel: AR when STREAM_TYPE=0, AW when STREAM_TYPE=1. It limits outstanding bursts and queues each burst's length and strobe for the data mover. One instance sits per direction between the streamer and the AXI master port.

## Interface
- STREAM_TYPE, 0: 0 = read (AR), 1 = write (AW).
- MAX_OUTSTANDING, 4: maximum bursts accepted but not completed; power of 2, from 2 to 16.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- dma_axi_req_i  in  s_dma_axi_req_t  valid, addr, alen, size, strb, mode from the streamer.
- dma_axi_resp_o  out  s_dma_axi_resp_t  .ready; the request is consumed in any cycle where valid && ready.
- ax_addr_o  out  DMA_ADDR_WIDTH  AXI AxADDR.
- ax_len_o  out  8  AXI AxLEN.
- ax_size_o  out  3  AXI AxSIZE.
- ax_burst_o  out  2  AXI AxBURST.
- ax_valid_o  out  1  AXI AxVALID.
- ax_ready_i  in  1  AXI AxREADY.
- txn_done_i  in  1  one burst completed: RLAST handshake (read) or B handshake (write).
- txn_err_i  in  1  qualifies txn_done_i; xRESP was SLVERR or DECERR.
- dp_valid_o  out  1  descriptor FIFO not empty.
- dp_alen_o  out  8  head entry: alen.
- dp_strb_o  out  axi_wr_strb_t  head entry: strb.
- dp_ready_i  in  1  data mover pops the head entry.
- err_clr_i  in  1  clears err_o.
- err_o  out  1  sticky error flag.
- idle_o  out  1  no pending request, nothing outstanding, FIFO empty.

## Operation
- Accept condition: `ready = (~ax_valid_o | ax_ready_i) & (os_cnt < MAX_OUTSTANDING)`. ready does not depend on dma_axi_req_i.valid.
- On accept, the block:
  - loads the AX register: addr, alen, size;
  - maps burst from mode: DMA_MODE_FIXED gives 2'b00, DMA_MODE_INCR gives 2'b01;
  - sets ax_valid_o;
  - pushes {alen, strb} into the descriptor FIFO;
  - increments os_cnt.
- ax_valid_o stays high with stable payload until ax_ready_i. On ax_ready_i without a new accept, it clears.
- os_cnt width is clog2(MAX_OUTSTANDING)+1.
  - It decrements on txn_done_i.
  - Accept and txn_done_i in the same cycle leave it unchanged.
  - txn_done_i while os_cnt==0 is ignored and sets err_o.
- FIFO depth equals MAX_OUTSTANDING, so the os_cnt limit prevents overflow. Push and pop in the same cycle are allowed, including when the FIFO is full.
- Pop when empty is ignored. Outputs are first-word fall-through.
- err_o sets on txn_done_i & txn_err_i, or on the underflow above.
  - It clears on err_clr_i.
  - If a set and err_clr_i occur in the same cycle, set wins.
- idle_o = ~ax_valid_o & (os_cnt==0) & FIFO empty.

## Timing
- Reset values:
  - ax_valid_o=0, ax_addr_o=0, ax_len_o=0, ax_size_o=0, ax_burst_o=0;
  - dp_valid_o=0, err_o=0, os_cnt=0, FIFO empty;
  - idle_o=1, ready=1.
- Accept in cycle N gives ax_valid_o in N+1 and dp_valid_o in N+1.
- Throughput is one burst per cycle when ax_ready_i is held high and os_cnt is below the limit.
- ready falls in the cycle after the accept that makes os_cnt reach MAX_OUTSTANDING. It rises in the cycle after txn_done_i.
- Reset mid-operation drops everything. Outstanding AXI bursts are not tracked after reset.

## Structure
- Reused from dma_utils_pkg: s_dma_axi_req_t, s_dma_axi_resp_t, dma_mode_t, axi_wr_strb_t, axi_alen_t.
- New in dma_utils_pkg: an axi_burst_t enum (FIXED=0, INCR=1, WRAP=2) and a mode-to-burst mapping function.
- One sub-module: `dma_fifo`, a parameterised sync FIFO (WIDTH, DEPTH) with full/empty, reusable elsewhere.

## Test plan
- Single burst: req addr=0x1000, alen=15, mode INCR, ax_ready_i held 1 -> ax_valid_o one cycle at N+1 with ax_len_o=15, ax_burst_o=01; dp_alen_o=15.
- Backpressure: ax_ready_i=0 for 5 cycles with req valid -> ready=0 after the first accept, payload stable, exactly one AR issued.
- Outstanding limit: MAX_OUTSTANDING=4, 6 reqs, no txn_done_i -> 4 accepted, ready=0. One txn_done_i -> 5th accepted the next cycle.
- Simultaneous accept and txn_done_i with os_cnt=3 -> os_cnt stays 3; FIFO push and pop leave the count unchanged.
- Error: txn_done_i with txn_err_i -> err_o=1. err_clr_i -> err_o=0. txn_done_i with os_cnt=0 -> err_o=1, os_cnt stays 0.
- FIXED write: STREAM_TYPE=1, mode FIXED, strb=0b0110 -> ax_burst_o=00, dp_strb_o=0b0110; reset mid-burst -> idle_o=1 the next cycle.
